operand_issue: RTL and testbench
================================

OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state on rising edge.
REQ-002 SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-003 SHALL have port instr_valid  in  1  instr holds a valid instruction.
REQ-004 SHALL have port instr  in  32  [31] imm_sel, [30:28] os, [27:24] rd, [23:20] rs1, [19:16] rs2, [5:0] shift; imm20 = [19:0] when imm_sel=1.
REQ-005 SHALL have port instr_ready  out  1  instruction accepted this cycle when instr_valid=1.
REQ-006 SHALL have port wb_en  in  1  writeback strobe.
REQ-007 SHALL have port wb_addr  in  4  writeback register index.
REQ-008 SHALL have port wb_data  in  32  writeback value.
REQ-009 SHALL have port sr1  out  32  ALU operand 1.
REQ-010 SHALL have port sr2  out  32  ALU operand 2.
REQ-011 SHALL have port os  out  3  ALU operation select, passed unchanged from instr[30:28].
REQ-012 SHALL have port shift  out  6  ALU shift amount.
REQ-013 SHALL have port alu_valid  out  1  sr1/sr2/os/shift/rd_addr hold a newly issued operation.
REQ-014 SHALL have port rd_addr  out  4  destination register of the issued operation.

Function
REQ-015 SHALL hold 16 x 32-bit registers; r0 reads 0 and ignores writes.
REQ-016 SHALL write wb_data to register wb_addr at the clock edge when wb_en=1 and wb_addr!=0.
REQ-017 SHALL return wb_data for a source read in a cycle where wb_en=1 and wb_addr equals that nonzero source index (write-through bypass).
REQ-018 SHALL keep a 16-bit pending scoreboard; bit n set means a result for rn is outstanding.
REQ-019 SHALL assert hazard when the pending bit of rs1 is set, when imm_sel=0 and the pending bit of rs2 is set, or when the pending bit of rd is set (WAW). A pending bit being cleared by wb_en in the same cycle counts as not pending.
REQ-020 SHALL drive instr_ready = !hazard combinationally; issue occurs when instr_valid & instr_ready.
REQ-021 SHALL, on issue, register sr1 = R[rs1]. If imm_sel=0, it SHALL register sr2 = R[rs2] and shift = instr[5:0]. If imm_sel=1, it SHALL register sr2 = sign-extended imm20 and shift = 0. It SHALL also register os and rd_addr, and set alu_valid=1 at the next edge (latency 1).
REQ-022 SHALL drive alu_valid=0 in every cycle following a non-issue cycle, and SHALL hold sr1/sr2/os/shift/rd_addr at their last issued values.
REQ-023 SHALL set pending[rd] on issue when rd!=0.
REQ-024 SHALL clear pending[wb_addr] on wb_en=1.
REQ-025 SHALL leave pending[n] set when issue sets pending[n] and wb_en clears pending[n] in the same cycle (set wins).
REQ-026 SHALL accept back-to-back independent instructions every cycle, with no bubble.
REQ-027 SHALL not restrict the number of outstanding results; up to 15 pending bits MAY be set at once.

Reset
REQ-028 SHALL, when reset_n=0 at a clock edge, clear all 16 registers, pending, alu_valid, sr1, sr2, os, shift, and rd_addr to 0.
REQ-029 SHALL hold instr_ready=1 during reset.
REQ-030 SHALL ignore any issue or writeback in a reset cycle; an operation interrupted by reset is discarded.

Structure
REQ-031 SHALL take instruction field positions, register count (16), and the imm20 width from shared package cpu_pkg.
REQ-032 SHALL implement register storage plus bypass as sub-module regfile16x32 (2 read ports, 1 write port, synchronous reset).
REQ-033 SHALL keep the scoreboard, hazard logic, and output pipeline register in operand_issue.

Verification
REQ-034 SHALL verify plain register issue: after reset, wb r1=9 and r2=1; instr imm_sel=0, os=3'b101, rd=3, rs1=1, rs2=2, shift=2 -> next cycle alu_valid=1, sr1=9, sr2=1, os=5, shift=2, rd_addr=3, pending[3]=1.
REQ-035 SHALL verify the RAW stall: with pending[3]=1, issue rs1=3 -> instr_ready=0 and alu_valid stays 0; wb r3=0xC in a later cycle -> issue in that same cycle with sr1=0xC.
REQ-036 SHALL verify the immediate form: imm_sel=1, imm20=0xFFFFF, rs1=0 -> sr1=0, sr2=0xFFFFFFFF, shift=0.
REQ-037 SHALL verify r0: wb r0=0x55 and issue rs1=0, rd=0 -> sr1=0 and pending stays all-zero.
REQ-038 SHALL verify set-wins: wb r4 in the same cycle as an issue with rd=4 -> pending[4]=1 afterwards, and the register holds the wb value.
REQ-039 SHALL verify reset mid-stream: reset_n=0 for one edge while alu_valid=1 and pending=0x00F0 -> all outputs and pending are 0, and instr_ready=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared CPU definitions: datapath width, register-file geometry,
//   instruction field positions, and small decode helpers used by the
//   operand issue stage and its register file.
//   No ports (package).
package cpu_pkg;

  localparam int XLEN     = 32;  // datapath width
  localparam int NUM_REGS = 16;  // architectural registers r0..r15
  localparam int REG_AW   = 4;   // register index width
  localparam int IMM_W    = 20;  // immediate field width
  localparam int SHIFT_W  = 6;   // shift amount width
  localparam int OS_W     = 3;   // ALU operation select width

  // Instruction field positions (LSB of each field)
  localparam int IMM_SEL_BIT = 31;
  localparam int OS_LSB      = 28;
  localparam int RD_LSB      = 24;
  localparam int RS1_LSB     = 20;
  localparam int RS2_LSB     = 16;
  localparam int SHIFT_LSB   = 0;
  localparam int IMM_LSB     = 0;

  typedef logic [XLEN-1:0]     word_t;
  typedef logic [REG_AW-1:0]   reg_idx_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;

  // Decoded view of an instruction word. rs2/shift and imm overlap in
  // the encoding; imm_sel decides which interpretation is meaningful.
  typedef struct packed {
    logic                imm_sel;
    logic [OS_W-1:0]     os;
    reg_idx_t            rd;
    reg_idx_t            rs1;
    reg_idx_t            rs2;
    logic [SHIFT_W-1:0]  shift;
    logic [IMM_W-1:0]    imm;
  } decoded_t;

  function automatic decoded_t decode(input word_t instr);
    decoded_t d;
    d.imm_sel = instr[IMM_SEL_BIT];
    d.os      = instr[OS_LSB +: OS_W];
    d.rd      = instr[RD_LSB +: REG_AW];
    d.rs1     = instr[RS1_LSB +: REG_AW];
    d.rs2     = instr[RS2_LSB +: REG_AW];
    d.shift   = instr[SHIFT_LSB +: SHIFT_W];
    d.imm     = instr[IMM_LSB +: IMM_W];
    return d;
  endfunction

  function automatic word_t sext_imm(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  // One-hot mask selecting register idx
  function automatic reg_mask_t idx_mask(input reg_idx_t idx);
    return reg_mask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/regfile16x32.sv
// regfile16x32
//   16 x 32-bit register file, two combinational read ports, one write
//   port. r0 always reads zero and is never written. A read of the
//   register being written in the same cycle returns the write data
//   (write-through bypass), so the issue stage never sees stale data.
// Ports:
//   clk            system clock
//   reset_n        synchronous active-low reset, clears every register
//   we/waddr/wdata write port (committed at the rising edge)
//   raddr1/rdata1  read port 1
//   raddr2/rdata2  read port 2
module regfile16x32
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     we,
  input  reg_idx_t waddr,
  input  word_t    wdata,
  input  reg_idx_t raddr1,
  input  reg_idx_t raddr2,
  output word_t    rdata1,
  output word_t    rdata2
);

  word_t    mem_reg [NUM_REGS];
  reg_idx_t raddr [2];
  word_t    rdata [2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;

  // Identical read-port logic for both ports: r0 is hard zero, then
  // the in-flight write wins over the stored value.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
      assign rdata[gi] = (raddr[gi] == '0)                ? '0    :
                         (we && (waddr == raddr[gi]))     ? wdata :
                                                            mem_reg[raddr[gi]];
    end
  endgenerate

  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];

endmodule

// File: rtl/operand_issue.sv
// operand_issue
//   Operand fetch / issue stage. Decodes an instruction, reads its
//   sources from the register file, stalls on RAW/WAW hazards using a
//   per-register pending scoreboard, and registers the ALU operands one
//   cycle after issue.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   instr_valid, instr           incoming instruction
//   instr_ready                  instruction accepted this cycle if valid
//   wb_en, wb_addr, wb_data      result writeback (also clears pending)
//   sr1, sr2, os, shift, rd_addr registered ALU operation
//   alu_valid                    operation registers hold a new issue
module operand_issue
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  output logic               instr_ready,
  input  logic               wb_en,
  input  logic [REG_AW-1:0]  wb_addr,
  input  logic [XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]    sr1,
  output logic [XLEN-1:0]    sr2,
  output logic [OS_W-1:0]    os,
  output logic [SHIFT_W-1:0] shift,
  output logic               alu_valid,
  output logic [REG_AW-1:0]  rd_addr
);

  decoded_t dec;
  word_t    rf_rdata1;
  word_t    rf_rdata2;

  reg_mask_t pending_reg;
  reg_mask_t pending_next;
  reg_mask_t pending_eff;
  reg_mask_t clr_mask;
  reg_mask_t set_mask;
  logic      hazard;
  logic      issue;

  word_t              sr1_reg,       sr1_next;
  word_t              sr2_reg,       sr2_next;
  logic [OS_W-1:0]    os_reg,        os_next;
  logic [SHIFT_W-1:0] shift_reg,     shift_next;
  reg_idx_t           rd_addr_reg,   rd_addr_next;
  logic               alu_valid_reg, alu_valid_next;

  assign dec = decode(instr);

  regfile16x32 u_rf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr1  (dec.rs1),
    .raddr2  (dec.rs2),
    .rdata1  (rf_rdata1),
    .rdata2  (rf_rdata2)
  );

  // Scoreboard view for this cycle: a register whose result is being
  // written back right now is already satisfied (its data arrives via
  // the register-file bypass), so it no longer blocks issue.
  always_comb begin
    clr_mask    = '0;
    if (wb_en) begin
      clr_mask = idx_mask(wb_addr);
    end
    pending_eff = pending_reg & ~clr_mask;

    hazard = pending_eff[dec.rs1]
           | (!dec.imm_sel & pending_eff[dec.rs2])
           | pending_eff[dec.rd];
  end

  // Ready is forced high in reset, but nothing issues then.
  assign instr_ready = !reset_n | !hazard;
  assign issue       = reset_n & instr_valid & !hazard;

  // r0 never becomes pending. The set is applied after the clear so an
  // issue to the register being written back leaves it pending.
  always_comb begin
    set_mask = '0;
    if (issue && (dec.rd != '0)) begin
      set_mask = idx_mask(dec.rd);
    end
    pending_next = pending_eff | set_mask;
  end

  always_comb begin
    sr1_next       = sr1_reg;
    sr2_next       = sr2_reg;
    os_next        = os_reg;
    shift_next     = shift_reg;
    rd_addr_next   = rd_addr_reg;
    alu_valid_next = issue;
    if (issue) begin
      sr1_next     = rf_rdata1;
      os_next      = dec.os;
      rd_addr_next = dec.rd;
      if (dec.imm_sel) begin
        sr2_next   = sext_imm(dec.imm);
        shift_next = '0;
      end else begin
        sr2_next   = rf_rdata2;
        shift_next = dec.shift;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_reg   <= '0;
      sr1_reg       <= '0;
      sr2_reg       <= '0;
      os_reg        <= '0;
      shift_reg     <= '0;
      rd_addr_reg   <= '0;
      alu_valid_reg <= 1'b0;
    end else begin
      pending_reg   <= pending_next;
      sr1_reg       <= sr1_next;
      sr2_reg       <= sr2_next;
      os_reg        <= os_next;
      shift_reg     <= shift_next;
      rd_addr_reg   <= rd_addr_next;
      alu_valid_reg <= alu_valid_next;
    end
  end

  assign sr1       = sr1_reg;
  assign sr2       = sr2_reg;
  assign os        = os_reg;
  assign shift     = shift_reg;
  assign rd_addr   = rd_addr_reg;
  assign alu_valid = alu_valid_reg;

endmodule

// File: tb/tb_operand_issue.sv
// tb_operand_issue
//   Directed scenarios followed by random traffic, each cycle compared
//   against a behavioural model of the issue stage (register values,
//   set of outstanding destinations, last issued operation).
module tb_operand_issue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] sr1;
  logic [31:0] sr2;
  logic [2:0]  os;
  logic [5:0]  shift;
  logic        alu_valid;
  logic [3:0]  rd_addr;

  operand_issue dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .sr1         (sr1),
    .sr2         (sr2),
    .os          (os),
    .shift       (shift),
    .alu_valid   (alu_valid),
    .rd_addr     (rd_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_regs [16];
  bit          m_pend [16];
  logic        e_valid;
  logic [31:0] e_sr1;
  logic [31:0] e_sr2;
  logic [2:0]  e_os;
  logic [5:0]  e_shift;
  logic [3:0]  e_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input int o, input int rd, input int rs1, input int rs2, input int sh);
    return {1'b0, o[2:0], rd[3:0], rs1[3:0], rs2[3:0], 10'd0, sh[5:0]};
  endfunction

  function automatic logic [31:0] mk_i(input int o, input int rd, input int rs1, input logic [19:0] imm);
    return {1'b1, o[2:0], rd[3:0], rs1[3:0], imm};
  endfunction

  // Source value as seen this cycle: r0 is zero, a same-cycle write wins
  function automatic logic [31:0] m_read(input int n);
    if (n == 0) return 32'd0;
    if (wb_en && (int'(wb_addr) == n)) return wb_data;
    return m_regs[n];
  endfunction

  // Outstanding after accounting for a same-cycle writeback
  function automatic bit m_busy(input int n);
    return m_pend[n] && !(wb_en && (int'(wb_addr) == n));
  endfunction

  function automatic logic [15:0] m_pend_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 1'b0;
    end
    e_valid = 1'b0;
    e_sr1   = '0;
    e_sr2   = '0;
    e_os    = '0;
    e_shift = '0;
    e_rd    = '0;
  endtask

  // One clock cycle: drive, check ready, advance model at the edge,
  // then check every registered output and the scoreboard.
  task automatic step(input bit v, input logic [31:0] ins, input bit we,
                      input int wa, input logic [31:0] wd, input bit rn);
    int          rs1, rs2, rd;
    bit          imm, hz, iss;
    logic [31:0] imm20;
    instr_valid = v;
    instr       = ins;
    wb_en       = we;
    wb_addr     = wa[3:0];
    wb_data     = wd;
    reset_n     = rn;
    #1;
    imm = ins[31];
    rd  = int'(ins[27:24]);
    rs1 = int'(ins[23:20]);
    rs2 = int'(ins[19:16]);
    hz  = m_busy(rs1) || (!imm && m_busy(rs2)) || m_busy(rd);
    check_eq("ready", {31'd0, instr_ready}, {31'd0, (!rn || !hz)});
    iss = rn && v && !hz;
    @(posedge clk);
    if (!rn) begin
      model_reset();
      $display("reset");
    end else begin
      e_valid = iss;
      if (iss) begin
        e_sr1 = m_read(rs1);
        e_os  = ins[30:28];
        e_rd  = ins[27:24];
        if (imm) begin
          imm20   = {12'd0, ins[19:0]};
          e_sr2   = (imm20 >= 32'h80000) ? imm20 + 32'hFFF0_0000 : imm20;
          e_shift = 6'd0;
        end else begin
          e_sr2   = m_read(rs2);
          e_shift = ins[5:0];
        end
        $display("issue rd=%0d os=%0d sr1=%08h sr2=%08h shift=%0d", e_rd, e_os, e_sr1, e_sr2, e_shift);
      end
      if (we && wa != 0) m_regs[wa] = wd;
      if (we) m_pend[wa] = 1'b0;
      if (iss && rd != 0) m_pend[rd] = 1'b1;
    end
    #1;
    check_eq("alu_valid", {31'd0, alu_valid}, {31'd0, e_valid});
    check_eq("sr1", sr1, e_sr1);
    check_eq("sr2", sr2, e_sr2);
    check_eq("os", {29'd0, os}, {29'd0, e_os});
    check_eq("shift", {26'd0, shift}, {26'd0, e_shift});
    check_eq("rd_addr", {28'd0, rd_addr}, {28'd0, e_rd});
    check_eq("pending", {16'd0, dut.pending_reg}, {16'd0, m_pend_vec()});
  endtask

  initial begin
    model_reset();
    instr_valid = 1'b0;
    instr       = '0;
    wb_en       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    reset_n     = 1'b0;

    // Reset, then plain register issue
    step(0, 32'd0, 0, 0, 32'd0, 0);
    step(0, 32'd0, 1, 1, 32'd9, 1);
    step(0, 32'd0, 1, 2, 32'd1, 1);
    step(1, mk_r(5, 3, 1, 2, 2), 0, 0, 32'd0, 1);
    check_eq("d_plain_valid", {31'd0, alu_valid}, 32'd1);
    check_eq("d_plain_sr1", sr1, 32'd9);
    check_eq("d_plain_sr2", sr2, 32'd1);
    check_eq("d_plain_os", {29'd0, os}, 32'd5);
    check_eq("d_plain_shift", {26'd0, shift}, 32'd2);
    check_eq("d_plain_rd", {28'd0, rd_addr}, 32'd3);
    check_eq("d_plain_pend3", {31'd0, dut.pending_reg[3]}, 32'd1);

    // RAW stall on r3, released by a same-cycle writeback
    step(1, mk_r(0, 6, 3, 0, 0), 0, 0, 32'd0, 1);
    check_eq("d_raw_stall_valid", {31'd0, alu_valid}, 32'd0);
    step(1, mk_r(0, 6, 3, 0, 0), 1, 3, 32'hC, 1);
    check_eq("d_raw_valid", {31'd0, alu_valid}, 32'd1);
    check_eq("d_raw_sr1", sr1, 32'hC);

    // Immediate form with all-ones imm20
    step(1, mk_i(1, 5, 0, 20'hFFFFF), 0, 0, 32'd0, 1);
    check_eq("d_imm_sr1", sr1, 32'd0);
    check_eq("d_imm_sr2", sr2, 32'hFFFF_FFFF);
    check_eq("d_imm_shift", {26'd0, shift}, 32'd0);

    // r0 ignores writes and never becomes pending
    step(0, 32'd0, 0, 0, 32'd0, 0);
    step(1, mk_r(2, 0, 0, 0, 7), 1, 0, 32'h55, 1);
    check_eq("d_r0_sr1", sr1, 32'd0);
    check_eq("d_r0_pend", {16'd0, dut.pending_reg}, 32'd0);

    // Set wins over a same-cycle clear
    step(1, mk_r(1, 4, 0, 0, 0), 1, 4, 32'h1234, 1);
    check_eq("d_setwins_pend4", {31'd0, dut.pending_reg[4]}, 32'd1);
    check_eq("d_setwins_r4", dut.u_rf.mem_reg[4], 32'h1234);

    // Back-to-back issues to r4..r7, then reset mid-stream
    step(0, 32'd0, 0, 0, 32'd0, 0);
    for (int i = 4; i < 8; i++) begin
      step(1, mk_r(i - 4, i, 0, 0, i), 0, 0, 32'd0, 1);
    end
    check_eq("d_stream_pend", {16'd0, dut.pending_reg}, 32'h00F0);
    check_eq("d_stream_valid", {31'd0, alu_valid}, 32'd1);
    step(1, mk_r(3, 8, 0, 0, 1), 1, 9, 32'hAA, 0);
    check_eq("d_rst_ready", {31'd0, instr_ready}, 32'd1);
    check_eq("d_rst_valid", {31'd0, alu_valid}, 32'd0);
    check_eq("d_rst_pend", {16'd0, dut.pending_reg}, 32'd0);
    check_eq("d_rst_sr1", sr1, 32'd0);
    check_eq("d_rst_rd", {28'd0, rd_addr}, 32'd0);
    check_eq("d_rst_r9", dut.u_rf.mem_reg[9], 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit          v, we, rn;
      int          wa;
      logic [31:0] ins, wd;
      v   = ($urandom_range(3, 0) != 0);
      we  = ($urandom_range(1, 0) != 0);
      wa  = int'($urandom_range(15, 0));
      wd  = $urandom;
      rn  = ($urandom_range(63, 0) != 0);
      ins = $urandom;
      // Narrow register indices now and then so hazards and bypasses occur
      if ($urandom_range(1, 0) != 0) begin
        ins[27:24] = 4'($urandom_range(3, 0));
        ins[23:20] = 4'($urandom_range(3, 0));
        ins[19:16] = 4'($urandom_range(3, 0));
        wa         = int'($urandom_range(3, 0));
      end
      step(v, ins, we, wa, wd, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
